// File: rtl/input_scheduler.sv
// input_scheduler: merges keyboard and UART byte streams onto the single command-handler port.
// Keyboard has priority, limited by MAX_BURST; define FLOW_XOFF_EN to enable xoff_req hysteresis.

module input_scheduler_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [7:0]              push_data,
    input  logic                    pop,
    output logic [7:0]              head,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

module input_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4
`ifdef FLOW_XOFF_EN
    ,
    parameter int XOFF_HIGH  = 3,
    parameter int XON_LOW    = 1
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    input  logic [7:0] uart_data,
    input  logic       uart_valid,
    output logic       uart_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_from_uart,
    input  logic       out_ready,
    output logic       xoff_req
);
    localparam int              CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [7:0]      BURST_LIMIT = 8'(MAX_BURST);

    logic [7:0]    kbd_head;
    logic [7:0]    uart_head;
    logic [CW-1:0] kbd_count;
    logic [CW-1:0] uart_count;
    logic          kbd_push;
    logic          uart_push;
    logic          kbd_has;
    logic          uart_has;
    logic          load;
    logic          grant_kbd;
    logic          grant_uart;
    logic [7:0]    burst_cnt;

    // Ready comes only from registered occupancy, so a pop never frees a full FIFO in the same cycle.
    assign kbd_ready  = (kbd_count != FULL_COUNT);
    assign uart_ready = (uart_count != FULL_COUNT);
    assign kbd_push   = kbd_valid && kbd_ready;
    assign uart_push  = uart_valid && uart_ready;
    assign kbd_has    = (kbd_count != '0);
    assign uart_has   = (uart_count != '0);

    assign load       = !out_valid || out_ready;
    assign grant_uart = load && uart_has && (!kbd_has || burst_cnt >= BURST_LIMIT);
    assign grant_kbd  = load && kbd_has && !grant_uart;

    input_scheduler_fifo #(.DEPTH(FIFO_DEPTH)) u_kbd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (kbd_push),
        .push_data (kbd_data),
        .pop       (grant_kbd),
        .head      (kbd_head),
        .count     (kbd_count)
    );

    input_scheduler_fifo #(.DEPTH(FIFO_DEPTH)) u_uart_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (uart_push),
        .push_data (uart_data),
        .pop       (grant_uart),
        .head      (uart_head),
        .count     (uart_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_from_uart <= 1'b0;
        end else if (load) begin
            out_valid <= grant_kbd || grant_uart;
            if (grant_uart) begin
                out_data      <= uart_head;
                out_from_uart <= 1'b1;
            end else if (grant_kbd) begin
                out_data      <= kbd_head;
                out_from_uart <= 1'b0;
            end
        end
    end

    // Counts keyboard wins only while UART is waiting; an empty UART FIFO or a UART win restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (!uart_has || grant_uart) begin
            burst_cnt <= '0;
        end else if (grant_kbd) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

`ifdef FLOW_XOFF_EN
    localparam logic [CW-1:0] XOFF_SET = CW'(XOFF_HIGH);
    localparam logic [CW-1:0] XON_CLR  = CW'(XON_LOW);

    always_ff @(posedge clk) begin
        if (reset) begin
            xoff_req <= 1'b0;
        end else if (uart_count >= XOFF_SET) begin
            xoff_req <= 1'b1;
        end else if (uart_count <= XON_CLR) begin
            xoff_req <= 1'b0;
        end
    end
`else
    assign xoff_req = 1'b0;
`endif
endmodule
